ksa_pipe_adder: RTL

Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready handshake. It is the width-generic, registered successor to the fixed 8-bit combinational prefix adder in the MAC datapath, and serves as the accumulate adder behind the multiplier. Prefix levels are split into register groups so the adder closes timing at the MAC clock. The block adds subtract mode, an external carry-in and signed-overflow detection.

---
 rtl/ksa_pipe_adder_if.sv | 31 +++
 rtl/ksa_pipe_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ksa_pipe_adder_if.sv
// ksa_pipe_adder_if
// Operand/result handshake bundle for the pipelined Kogge-Stone adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// master: the side that supplies operands and consumes results.
// slave : the adder itself.
interface ksa_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder
// Width-generic pipelined Kogge-Stone adder/subtractor.
//   add: sum = a + b + cin     sub: sum = a - b  (a + ~b + 1, cin ignored)
//   cout: carry out of the MSB (in subtract mode 1 = no borrow)
//   ovf : two's-complement signed overflow
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ksa_pipe_adder_if.slave operand/result handshake
// Pipeline: stage 0 registers bitwise g/p, then the clog2(WIDTH) prefix levels
// are cut into STAGES groups of REG_EVERY levels; the last group feeds the
// sum/cout/ovf output register. Latency = 1 + STAGES. All stages advance
// together whenever the output is not stalled.
module ksa_pipe_adder #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ksa_pipe_adder_if.slave  bus
);

  localparam int L      = $clog2(WIDTH);
  localparam int STAGES = (L + REG_EVERY - 1) / REG_EVERY;

  // Apply prefix levels first..first+REG_EVERY-1 (clipped to L) to a (G,P)
  // pair. Returned packed as {G, P}.
  function automatic logic [2*WIDTH-1:0] prefix_group(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int               first
  );
    logic [WIDTH-1:0] g, p, gn, pn;
    int span;
    g = g_in;
    p = p_in;
    for (int k = 1; k <= L; k++) begin
      if (k >= first && k < first + REG_EVERY) begin
        span = 1 << (k - 1);
        gn = g;
        pn = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= span) begin
            gn[i] = g[i] | (p[i] & g[i - span]);
            pn[i] = p[i] & p[i - span];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return {g, p};
  endfunction

  // Final carries with c0 acting as the generate of bit -1, then the sum bits
  // and signed overflow. Returned packed as {cout, ovf, sum}.
  function automatic logic [WIDTH+1:0] finalize(
    input logic [2*WIDTH-1:0] gp,
    input logic [WIDTH-1:0]   p,
    input logic               c0,
    input logic               a_msb,
    input logic               b_msb
  );
    logic [WIDTH-1:0] c, s;
    c = gp[2*WIDTH-1:WIDTH] | (gp[WIDTH-1:0] & {WIDTH{c0}});
    s = p ^ {c[WIDTH-2:0], c0};
    return {c[WIDTH-1], (a_msb == b_msb) && (s[WIDTH-1] != a_msb), s};
  endfunction

  // Per-stage state. Index s in 0..STAGES-1 is the register ahead of prefix
  // group s; vld_p[STAGES] is the output stage valid.
  logic [WIDTH-1:0]   gg_p   [STAGES];
  logic [WIDTH-1:0]   pp_p   [STAGES];
  logic [WIDTH-1:0]   p_p    [STAGES];
  logic               c0_p   [STAGES];
  logic               amsb_p [STAGES];
  logic               bmsb_p [STAGES];
  logic               vld_p  [STAGES+1];
  logic [WIDTH-1:0]   sum_p;
  logic               cout_p;
  logic               ovf_p;

  logic [2*WIDTH-1:0] grp [STAGES];
  logic [WIDTH+1:0]   fin;
  logic [WIDTH-1:0]   b_eff;
  logic               adv;

  assign adv          = ~(vld_p[STAGES] & ~bus.out_ready);
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      grp[s] = prefix_group(gg_p[s], pp_p[s], s * REG_EVERY + 1);
    end
    fin = finalize(grp[STAGES-1], p_p[STAGES-1], c0_p[STAGES-1],
                   amsb_p[STAGES-1], bmsb_p[STAGES-1]);
  end

  // Control: valid bits and the visible output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) vld_p[s] <= 1'b0;
      sum_p  <= '0;
      cout_p <= 1'b0;
      ovf_p  <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= bus.in_valid;
      for (int s = 1; s <= STAGES; s++) vld_p[s] <= vld_p[s-1];
      // Output stage: last prefix group plus sum/flag formation.
      if (vld_p[STAGES-1]) {cout_p, ovf_p, sum_p} <= fin;
    end
  end

  // Datapath registers; only loaded when a valid beat moves into them.
  always_ff @(posedge clk) begin
    if (adv) begin
      // Stage 0: operand conditioning and bitwise generate/propagate.
      if (bus.in_valid) begin
        gg_p[0]   <= bus.a & b_eff;
        pp_p[0]   <= bus.a ^ b_eff;
        p_p[0]    <= bus.a ^ b_eff;
        c0_p[0]   <= bus.sub | bus.cin;
        amsb_p[0] <= bus.a[WIDTH-1];
        bmsb_p[0] <= b_eff[WIDTH-1];
      end
      // Stages 1..STAGES-1: boundaries between prefix groups.
      for (int s = 1; s < STAGES; s++) begin
        if (vld_p[s-1]) begin
          gg_p[s]   <= grp[s-1][2*WIDTH-1:WIDTH];
          pp_p[s]   <= grp[s-1][WIDTH-1:0];
          p_p[s]    <= p_p[s-1];
          c0_p[s]   <= c0_p[s-1];
          amsb_p[s] <= amsb_p[s-1];
          bmsb_p[s] <= bmsb_p[s-1];
        end
      end
    end
  end

  assign bus.out_valid = vld_p[STAGES];
  assign bus.sum       = sum_p;
  assign bus.cout      = cout_p;
  assign bus.ovf       = ovf_p;

endmodule
